// File: rtl/seq_shift_register.sv
// seq_shift_register: multi-cycle universal shift register with a start/busy/done
// handshake, one single-bit step per clock, and a carried write strobe/address.
// Optional feature macro: SHREG_ARITH_EN (mode 6 = arithmetic shift right;
// when undefined, mode 6 executes as hold for the requested number of cycles).
module seq_shift_register #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ADDRWIDTH = 4,
   localparam int unsigned CW       = $clog2(WIDTH) + 1
) (
   input  logic                 Clock,
   input  logic                 Clear,
   input  logic                 start,
   input  logic [2:0]           mode,
   input  logic [CW-1:0]        count,
   input  logic [WIDTH-1:0]     D,
   input  logic                 MSBIn,
   input  logic                 LSBIn,
   input  logic                 wr_en,
   input  logic [ADDRWIDTH-1:0] addr,
   output logic [WIDTH-1:0]     Q,
   output logic                 SerOut,
   output logic                 busy,
   output logic                 done,
   output logic                 wr_en_ff,
   output logic [ADDRWIDTH-1:0] addr_ff
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] M_HOLD  = 3'd0;
   localparam logic [2:0] M_LOAD  = 3'd1;
   localparam logic [2:0] M_SHR   = 3'd2;
   localparam logic [2:0] M_SHL   = 3'd3;
   localparam logic [2:0] M_ROR   = 3'd4;
   localparam logic [2:0] M_ROL   = 3'd5;
   localparam logic [2:0] M_ASR   = 3'd6;
   localparam logic [2:0] M_CLEAR = 3'd7;

   state_t                 state, state_n;
   logic [2:0]             mode_r, mode_n;
   logic [CW-1:0]          steps, steps_n;
   logic                   wr_en_r, wr_n;
   logic [WIDTH-1:0]       q_n;
   logic                   ser_n;
   logic [ADDRWIDTH-1:0]   addr_n;
   logic                   busy_n, done_n, wr_ff_n;
   logic                   shift_mode;

   // Shift/rotate family takes its step count from the count port.
   assign shift_mode = (mode >= M_SHR) && (mode <= M_ASR);

   // State and datapath registers; Clear aborts to the all-zero state.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state    <= IDLE;
         mode_r   <= M_HOLD;
         steps    <= '0;
         wr_en_r  <= 1'b0;
         Q        <= '0;
         SerOut   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_en_ff <= 1'b0;
         addr_ff  <= '0;
      end else begin
         state    <= state_n;
         mode_r   <= mode_n;
         steps    <= steps_n;
         wr_en_r  <= wr_n;
         Q        <= q_n;
         SerOut   <= ser_n;
         busy     <= busy_n;
         done     <= done_n;
         wr_en_ff <= wr_ff_n;
         addr_ff  <= addr_n;
      end
   end

   // Next-state, command capture and per-step datapath update.
   always_comb begin
      state_n = state;
      mode_n  = mode_r;
      steps_n = steps;
      wr_n    = wr_en_r;
      addr_n  = addr_ff;
      q_n     = Q;
      ser_n   = SerOut;

      case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               wr_n    = wr_en;
               addr_n  = addr;
               // A zero count still spends one RUN cycle, executed as hold.
               mode_n  = (shift_mode && (count == '0)) ? M_HOLD : mode;
               if (!shift_mode || (count == '0))
                  steps_n = CW'(1);
               else if (count > CW'(WIDTH))
                  steps_n = CW'(WIDTH);
               else
                  steps_n = count;
            end
         end
         RUN: begin
            case (mode_r)
               M_LOAD:  q_n = D;
               M_SHR: begin
                  q_n   = {MSBIn, Q[WIDTH-1:1]};
                  ser_n = Q[0];
               end
               M_SHL: begin
                  q_n   = {Q[WIDTH-2:0], LSBIn};
                  ser_n = Q[WIDTH-1];
               end
               M_ROR: begin
                  q_n   = {Q[0], Q[WIDTH-1:1]};
                  ser_n = Q[0];
               end
               M_ROL: begin
                  q_n   = {Q[WIDTH-2:0], Q[WIDTH-1]};
                  ser_n = Q[WIDTH-1];
               end
               M_ASR: begin
`ifdef SHREG_ARITH_EN
                  q_n   = {Q[WIDTH-1], Q[WIDTH-1:1]};
                  ser_n = Q[0];
`else
                  q_n   = Q;
`endif
               end
               M_CLEAR: q_n = '0;
               default: q_n = Q;
            endcase
            steps_n = steps - CW'(1);
            if (steps == CW'(1))
               state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      busy_n  = (state_n != IDLE);
      done_n  = (state_n == DONE);
      wr_ff_n = wr_n & done_n;
   end

endmodule
